// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction memory, decoder handshake, redirect and halt.
// Build option FETCH_PERF_EN adds the perf_fetched/perf_stall counters to the bundle.
interface fetch_unit_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [15:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic            halted;
`ifdef FETCH_PERF_EN
  logic [15:0]     perf_fetched;
  logic [15:0]     perf_stall;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, halted, perf_fetched, perf_stall,
    input  imem_ack, imem_data, instr_ready, redirect, redirect_pc, halt
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted, perf_fetched, perf_stall,
    output imem_ack, imem_data, instr_ready, redirect, redirect_pc, halt
  );
`else
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
    input  imem_ack, imem_data, instr_ready, redirect, redirect_pc, halt
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
    output imem_ack, imem_data, instr_ready, redirect, redirect_pc, halt
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, small instruction buffer, redirect/halt.
// Build option FETCH_PERF_EN adds pop and stall performance counters.
module fetch_unit #(
  parameter int PC_W      = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [2:0]      r_count;
  logic [1:0]      r_rd;
  logic [1:0]      r_wr;
  logic [15:0]     r_data [0:3];
  logic [PC_W-1:0] r_pcs  [0:3];
  logic [15:0]     r_instr;
  logic [PC_W-1:0] r_instr_pc;
  logic            r_valid;
  logic            r_halted;

  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_rd_next;
  logic [2:0]      w_count_next;
  logic [2:0]      w_remain;
  logic [15:0]     w_head_data;
  logic [PC_W-1:0] w_head_pc;

  always_comb begin
    w_req        = 1'b0;
    w_head_data  = 16'h0000;
    w_head_pc    = '0;
    if (!rst && (r_state == ST_RUN) && (r_count < DEPTH) && !bus.redirect && !bus.halt) begin
      w_req = 1'b1;
    end else begin
      w_req = 1'b0;
    end
    w_push       = w_req && bus.imem_ack;
    w_pop        = r_valid && bus.instr_ready;
    w_rd_next    = w_pop ? ptr_inc(r_rd) : r_rd;
    w_count_next = r_count + {2'b00, w_push} - {2'b00, w_pop};
    // Entries surviving from before this cycle; if none, the new head is the word being pushed.
    w_remain     = r_count - {2'b00, w_pop};
    if (w_remain == 3'd0) begin
      w_head_data = bus.imem_data;
      w_head_pc   = r_pc;
    end else begin
      w_head_data = r_data[w_rd_next];
      w_head_pc   = r_pcs[w_rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= '0;
      r_count    <= 3'd0;
      r_rd       <= 2'd0;
      r_wr       <= 2'd0;
      r_instr    <= 16'h0000;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= 16'h0000;
        r_pcs[i]  <= '0;
      end
    end else if (r_state == ST_HALT) begin
      r_valid  <= 1'b0;
      r_halted <= 1'b1;
    end else if (bus.halt) begin
      r_state  <= ST_HALT;
      r_halted <= 1'b1;
      r_count  <= 3'd0;
      r_rd     <= 2'd0;
      r_wr     <= 2'd0;
      r_valid  <= 1'b0;
    end else if (bus.redirect) begin
      r_pc    <= bus.redirect_pc;
      r_count <= 3'd0;
      r_rd    <= 2'd0;
      r_wr    <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_data[r_wr] <= bus.imem_data;
        r_pcs[r_wr]  <= r_pc;
        r_wr         <= ptr_inc(r_wr);
        r_pc         <= r_pc + 1'b1;
      end
      r_rd    <= w_rd_next;
      r_count <= w_count_next;
      // An empty buffer keeps the last instr/instr_pc on the outputs.
      if (w_count_next != 3'd0) begin
        r_instr    <= w_head_data;
        r_instr_pc <= w_head_pc;
        r_valid    <= 1'b1;
      end else begin
        r_valid    <= 1'b0;
      end
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = r_halted;

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= 16'h0000;
      r_perf_stall   <= 16'h0000;
    end else if (r_state == ST_RUN) begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 16'h0001;
      end else begin
        r_perf_fetched <= r_perf_fetched;
      end
      if (r_valid && !bus.instr_ready) begin
        r_perf_stall <= r_perf_stall + 16'h0001;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
    end else begin
      r_perf_fetched <= r_perf_fetched;
      r_perf_stall   <= r_perf_stall;
    end
  end

  assign bus.perf_fetched = r_perf_fetched;
  assign bus.perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait and 3-cycle memory, stall, redirect, PC wrap, halt.
module tb_fetch_unit;
  localparam int PC_W = 8;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 0;
  int   wcnt  = 0;
  logic force_ack = 1'b0;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word = 16'h1000 + addr, ack after lat extra request cycles.
  assign bus.imem_ack  = force_ack | (bus.imem_req && (wcnt >= lat));
  assign bus.imem_data = 16'h1000 + {8'h00, bus.imem_addr};

  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req",    32'(bus.imem_req),    32'h0);
    chk("rst_addr",   32'(bus.imem_addr),   32'h0);
    chk("rst_instr",  32'(bus.instr),       32'h0);
    chk("rst_pc",     32'(bus.instr_pc),    32'h0);
    chk("rst_valid",  32'(bus.instr_valid), 32'h0);
    chk("rst_halted", 32'(bus.halted),      32'h0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.halt        = 1'b0;

    // Zero-wait memory, decoder always ready.
    lat = 0;
    do_reset();
    chk("c1_req",   32'(bus.imem_req),    32'h1);
    chk("c1_addr",  32'(bus.imem_addr),   32'h0);
    chk("c1_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("c2_valid", 32'(bus.instr_valid), 32'h1);
    chk("c2_instr", 32'(bus.instr),       32'h1000);
    chk("c2_pc",    32'(bus.instr_pc),    32'h00);
    tick();
    chk("c3_instr", 32'(bus.instr),       32'h1001);
    chk("c3_pc",    32'(bus.instr_pc),    32'h01);
    tick();
    chk("c4_instr", 32'(bus.instr),       32'h1002);
    chk("c4_pc",    32'(bus.instr_pc),    32'h02);
    chk("c4_valid", 32'(bus.instr_valid), 32'h1);

    // Decoder stalls: buffer fills to 2 and requests stop.
    bus.instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",   32'(bus.imem_req),    32'h0);
      chk("stall_valid", 32'(bus.instr_valid), 32'h1);
      chk("stall_instr", 32'(bus.instr),       32'h1000);
      if (i < 4) tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("rel_instr1", 32'(bus.instr),    32'h1001);
    chk("rel_pc1",    32'(bus.instr_pc), 32'h01);
    tick();
    chk("rel_instr2", 32'(bus.instr),    32'h1002);
    chk("rel_pc2",    32'(bus.instr_pc), 32'h02);

    // Three-cycle ack latency.
    lat = 2;
    do_reset();
    chk("lat_c1_addr", 32'(bus.imem_addr), 32'h0);
    chk("lat_c1_ack",  32'(bus.imem_ack),  32'h0);
    tick();
    chk("lat_c2_addr", 32'(bus.imem_addr), 32'h0);
    chk("lat_c2_req",  32'(bus.imem_req),  32'h1);
    tick();
    chk("lat_c3_ack",  32'(bus.imem_ack),  32'h1);
    tick();
    chk("lat_c4_valid", 32'(bus.instr_valid), 32'h1);
    chk("lat_c4_instr", 32'(bus.instr),       32'h1000);
    chk("lat_c4_addr",  32'(bus.imem_addr),   32'h1);
    tick();
    chk("lat_c5_valid", 32'(bus.instr_valid), 32'h0);
    chk("lat_c5_hold",  32'(bus.instr),       32'h1000);
    chk("lat_c5_addr",  32'(bus.imem_addr),   32'h1);
    tick();
    chk("lat_c6_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("lat_c7_valid", 32'(bus.instr_valid), 32'h1);
    chk("lat_c7_instr", 32'(bus.instr),       32'h1001);
    chk("lat_c7_pc",    32'(bus.instr_pc),    32'h01);

    // Redirect with a full buffer and a stray ack in the same cycle.
    lat = 0;
    bus.instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    force_ack       = 1'b1;
    #1;
    chk("redir_req", 32'(bus.imem_req), 32'h0);
    tick();
    bus.redirect    = 1'b0;
    force_ack       = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    chk("redir_valid", 32'(bus.instr_valid), 32'h0);
    chk("redir_req2",  32'(bus.imem_req),    32'h1);
    chk("redir_addr",  32'(bus.imem_addr),   32'h40);
    tick();
    chk("redir_pc",    32'(bus.instr_pc),    32'h40);
    chk("redir_instr", 32'(bus.instr),       32'h1040);

    // PC wrap after redirect to 8'hFE.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFE;
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("wrap_addr", 32'(bus.imem_addr), 32'hFE);
    tick();
    chk("wrap_pc0", 32'(bus.instr_pc), 32'hFE);
    chk("wrap_i0",  32'(bus.instr),    32'h10FE);
    tick();
    chk("wrap_pc1", 32'(bus.instr_pc), 32'hFF);
    chk("wrap_i1",  32'(bus.instr),    32'h10FF);
    tick();
    chk("wrap_pc2", 32'(bus.instr_pc), 32'h00);
    chk("wrap_i2",  32'(bus.instr),    32'h1000);

    // Halt together with redirect: halt wins and is terminal.
    bus.halt        = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h80;
    #1;
    chk("halt_req0", 32'(bus.imem_req), 32'h0);
    tick();
    bus.halt        = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h20;
    #1;
    chk("halted1",    32'(bus.halted),      32'h1);
    chk("halt_valid", 32'(bus.instr_valid), 32'h0);
    chk("halt_req1",  32'(bus.imem_req),    32'h0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("halted2",   32'(bus.halted),    32'h1);
    chk("halt_req2", 32'(bus.imem_req),  32'h0);
    chk("halt_addr", 32'(bus.imem_addr), 32'h01);
    tick();
    chk("halt_req3", 32'(bus.imem_req),  32'h0);

    do_reset();
    chk("restart_req",  32'(bus.imem_req),  32'h1);
    chk("restart_addr", 32'(bus.imem_addr), 32'h0);
    tick();
    chk("restart_instr", 32'(bus.instr), 32'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the 16-bit instruction decoder. It holds the PC, issues requests to instruction memory with a req/ack handshake, and buffers returned words with their PCs in a small FIFO. It presents instructions to the decoder with valid/ready, and handles redirects (jump/branch/JR) and halt (EOE) from downstream.

Parameters:
PC_W, 8, PC / instruction-memory address width in bits (matches the 8-bit immediate).
BUF_DEPTH, 2, instruction buffer entries; legal values are 2 to 4.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_W  fetch address; stable while imem_req=1 and no ack
imem_ack  input  1  memory response; imem_data valid this cycle
imem_data  input  16  instruction word
instr  output  16  instruction at buffer head, to decoder
instr_pc  output  PC_W  PC of instr (JAL link source)
instr_valid  output  1  buffer head valid
instr_ready  input  1  decoder accepts instr this cycle
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  PC_W  new fetch address
halt  input  1  EOE seen downstream; stop fetching
halted  output  1  fetch stopped

Behaviour:
- Reset (rst=1 at an edge): pc=0, buffer empty, imem_req=0, imem_addr=0, instr=16'h0000, instr_pc=0, instr_valid=0, halted=0. Reset takes priority over every other input, including mid-request. A pending memory transaction is abandoned.
- FSM states:
  - RUN: fetching.
  - HALT: terminal until rst.
- RUN request rule:
  - imem_req=1 when count<BUF_DEPTH, no redirect, and no halt. count is the registered occupancy.
  - imem_addr=pc.
  - First request is in the first cycle after rst deasserts, with addr=0.
- Handshake:
  - A transfer completes in any cycle with imem_req=1 and imem_ack=1.
  - On completion, {pc, imem_data} is pushed and pc <= pc+1.
  - Without ack, pc and imem_addr hold.
  - Memory may ack in the request cycle (zero wait) or later. It must tolerate imem_req being withdrawn.
  - imem_ack with imem_req=0 is ignored.
- Latency: ack at edge N gives instr_valid=1 from cycle N+1, for an empty buffer.
- Throughput: zero-wait memory with instr_ready=1 sustains one instruction per cycle.
- Pop: instr_valid && instr_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Buffer full (count=BUF_DEPTH): no request is issued. Overflow is impossible by construction.
- Buffer empty: instr_valid=0; instr and instr_pc hold their last values.
- PC wrap: pc=2^PC_W-1 increments to 0 with no flag.
- Redirect (RUN):
  - At the edge: buffer cleared, pc <= redirect_pc.
  - imem_req=0 during the redirect cycle; any ack in that cycle is discarded.
  - instr_valid=0 in the next cycle. Fetch restarts with a request in the next cycle, addr=redirect_pc.
  - A pop in the redirect cycle is still seen by the decoder; the flush applies after it.
- Halt:
  - In the halt cycle: imem_req=0 and any ack is discarded.
  - At the edge: buffer cleared, state becomes HALT, halted=1.
  - In HALT: imem_req=0, instr_valid=0; redirect and halt are ignored.
- Simultaneous halt and redirect: halt wins.

Optional Feature:
FETCH_PERF_EN
- Defined: adds two outputs.
  - perf_fetched (16 bits): increments on each accepted pop.
  - perf_stall (16 bits): increments each cycle with instr_valid=1 and instr_ready=0.
  - Both clear on rst, wrap at 16'hFFFF, and freeze in HALT.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Zero-wait memory returning 16'h1000+addr, instr_ready=1: after reset, instr_valid rises in cycle 2 and outputs 16'h1000, 16'h1001, 16'h1002 with instr_pc 0,1,2 on consecutive cycles.
- instr_ready=0 for 5 cycles: fill stops at 2 entries; imem_req=0 while full; instr holds 16'h1000. On release, the sequence continues with no loss or duplicate.
- Memory with 3-cycle ack latency: imem_addr stays stable until ack; one instruction per 3 cycles.
- redirect=1 with redirect_pc=8'h40 while the buffer holds 2 entries and an ack arrives the same cycle: buffered and acked words are dropped; the next delivered instr_pc=8'h40.
- PC wrap: redirect to 8'hFE, then fetch 3 words: instr_pc is FE, FF, 00.
- halt together with redirect: halted=1 next cycle, imem_req stays 0, further redirects are ignored. rst restarts fetch at addr 0.
